// File: rtl/pool_scheduler_if.sv
// Bundle between the pool scheduler, its feature-map producers, the pooling
// engine and the downstream consumer. master = scheduler, slave = environment.
interface pool_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 22,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        src_valid;
  logic [NUM_REQ*DATA_W-1:0] src_pixel;
  logic [NUM_REQ-1:0]        src_ready;
  logic [NUM_REQ-1:0]        grant_onehot;
  logic                      pool_start;
  logic                      pool_pixel_valid;
  logic [DATA_W-1:0]         pool_pixel;
  logic [DATA_W-1:0]         pool_result;
  logic                      pool_result_valid;
  logic                      pool_done;
  logic [DATA_W-1:0]         res_out;
  logic                      res_valid;
  logic [ID_W-1:0]           res_id;
  logic                      job_done;
  logic [ID_W-1:0]           job_id;
  logic                      err_count;

  modport master (
    input  req, src_valid, src_pixel, pool_result, pool_result_valid, pool_done,
    output src_ready, grant_onehot, pool_start, pool_pixel_valid, pool_pixel,
           res_out, res_valid, res_id, job_done, job_id, err_count
  );

  modport slave (
    output req, src_valid, src_pixel, pool_result, pool_result_valid, pool_done,
    input  src_ready, grant_onehot, pool_start, pool_pixel_valid, pool_pixel,
           res_out, res_valid, res_id, job_done, job_id, err_count
  );
endinterface

// File: rtl/pool_scheduler.sv
// Round-robin scheduler sharing one max-pooling engine between NUM_REQ producers:
// start pulse, combinational pixel feed from the owner, tagged result collection.
module pool_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30,
  parameter int DATA_W     = 22,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic              clk,
  input logic              rst,
  pool_scheduler_if.master bus
);

  localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int RES_TOTAL = (IMG_WIDTH / 2) * (IMG_HEIGHT / 2);
  localparam int PIX_W     = $clog2(PIX_TOTAL + 1);
  // One spare code above the expected total so an over-count stays distinguishable.
  localparam int RES_W     = $clog2(RES_TOTAL + 2);

  typedef enum logic [1:0] {IDLE, START, FEED, DRAIN} state_t;

  state_t             state;
  logic [ID_W-1:0]    owner;
  logic [ID_W-1:0]    last_id;
  logic [PIX_W-1:0]   pix_cnt;
  logic [RES_W-1:0]   res_cnt;
  logic [RES_W-1:0]   res_cnt_inc;
  logic [RES_W-1:0]   res_cnt_final;
  logic [NUM_REQ-1:0] grant_r;
  logic               pool_start_r;
  logic [DATA_W-1:0]  res_out_r;
  logic               res_valid_r;
  logic [ID_W-1:0]    res_id_r;
  logic               job_done_r;
  logic [ID_W-1:0]    job_id_r;
  logic               err_r;

  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] src_ready_c;
  logic               pix_valid_c;
  logic [DATA_W-1:0]  pix_c;
  logic               accept;
  logic [DATA_W-1:0]  pix_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign pix_arr[g] = bus.src_pixel[g*DATA_W +: DATA_W];
  end

  // Scan from the index just after the previous owner, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_id) + k) % NUM_REQ);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    src_ready_c = '0;
    pix_valid_c = 1'b0;
    pix_c       = '0;
    if (state == FEED) begin
      src_ready_c[owner] = 1'b1;
      pix_valid_c        = bus.src_valid[owner];
      pix_c              = pix_arr[owner];
    end
  end

  assign accept        = (state == FEED) && bus.src_valid[owner];
  assign res_cnt_inc   = (res_cnt == '1) ? res_cnt : res_cnt + 1'b1;
  assign res_cnt_final = bus.pool_result_valid ? res_cnt_inc : res_cnt;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      last_id      <= ID_W'(NUM_REQ - 1);
      pix_cnt      <= '0;
      res_cnt      <= '0;
      grant_r      <= '0;
      pool_start_r <= 1'b0;
      res_out_r    <= '0;
      res_valid_r  <= 1'b0;
      res_id_r     <= '0;
      job_done_r   <= 1'b0;
      job_id_r     <= '0;
      err_r        <= 1'b0;
    end else begin
      pool_start_r <= 1'b0;
      res_valid_r  <= 1'b0;
      job_done_r   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            owner        <= pick_id;
            last_id      <= pick_id;
            grant_r      <= NUM_REQ'(1) << pick_id;
            pool_start_r <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          pix_cnt <= '0;
          res_cnt <= '0;
          state   <= FEED;
        end
        FEED: begin
          if (accept) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == PIX_W'(PIX_TOTAL - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.pool_result_valid) begin
            res_out_r   <= bus.pool_result;
            res_id_r    <= owner;
            res_valid_r <= 1'b1;
            res_cnt     <= res_cnt_inc;
          end
          // A result arriving with done is counted before the total is judged.
          if (bus.pool_done) begin
            job_done_r <= 1'b1;
            job_id_r   <= owner;
            if (res_cnt_final != RES_W'(RES_TOTAL)) err_r <= 1'b1;
            grant_r    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.src_ready        = src_ready_c;
  assign bus.grant_onehot     = grant_r;
  assign bus.pool_start       = pool_start_r;
  assign bus.pool_pixel_valid = pix_valid_c;
  assign bus.pool_pixel       = pix_c;
  assign bus.res_out          = res_out_r;
  assign bus.res_valid        = res_valid_r;
  assign bus.res_id           = res_id_r;
  assign bus.job_done         = job_done_r;
  assign bus.job_id           = job_id_r;
  assign bus.err_count        = err_r;

endmodule
